register_file_multiport: RTL and testbench
==========================================

REGISTER_FILE_MULTIPORT -- requirements
Module: register_file_multiport

Interface
REQ-001 Parameter DATA_WIDTH, default 32, register width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_WIDTH, default 5, register address width; DEPTH = 2**ADDR_WIDTH.
REQ-003 Parameter BYPASS, default 1, 1 = same-cycle write-to-read forwarding, 0 = none.
REQ-004 Port clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 Port regWrite  input  1  write request.
REQ-007 Port writeRegister  input  ADDR_WIDTH  write address.
REQ-008 Port writeData  input  DATA_WIDTH  write data.
REQ-009 Port byteEnable  input  DATA_WIDTH/8  per-byte write mask, bit i covers writeData[8i+7:8i].
REQ-010 Port readRegister1  input  ADDR_WIDTH  read port 1 address.
REQ-011 Port readRegister2  input  ADDR_WIDTH  read port 2 address.
REQ-012 Port readData1  output  DATA_WIDTH  read port 1 data.
REQ-013 Port readData2  output  DATA_WIDTH  read port 2 data.
REQ-014 Port clearReq  input  1  request to zero the whole bank.
REQ-015 Port busy  output  1  high while the clear sweep runs.

Function
REQ-016 Register 0 SHALL read as 0 always; writes to address 0 SHALL be discarded.
REQ-017 Reads SHALL be combinational: readDataN = contents of register readRegisterN, no clock latency.
REQ-018 Write SHALL occur at the rising edge when regWrite=1, busy=0, writeRegister!=0; only byte lanes with byteEnable=1 updated, others retained.
REQ-019 regWrite=1 with byteEnable all-zero SHALL leave the register unchanged.
REQ-020 BYPASS=1: when a write is accepted (REQ-018 conditions) and readRegisterN==writeRegister, readDataN SHALL show the byte-merged post-write value in the same cycle.
REQ-021 BYPASS=0: readDataN SHALL show the old value until after the write edge.
REQ-022 Both read ports MAY address the same register and SHALL return identical data.
REQ-023 Clear FSM states: IDLE, CLEAR; IDLE -> CLEAR at the edge where clearReq=1; sweep counter loaded with 1.
REQ-024 In CLEAR, each edge SHALL zero register[counter] and increment counter; after zeroing register DEPTH-1, state SHALL return to IDLE (CLEAR lasts DEPTH-1 cycles).
REQ-025 busy SHALL be 1 exactly while state=CLEAR, registered (rises the cycle after clearReq sampled).
REQ-026 clearReq in CLEAR SHALL be ignored (no restart); clearReq held high through the IDLE return SHALL start a new sweep.
REQ-027 Writes while busy=1 SHALL be discarded; no bypass SHALL be applied while busy=1.
REQ-028 Reads while busy=1 SHALL return current contents (partially cleared bank is visible).
REQ-029 clearReq and accepted write in the same IDLE cycle: write SHALL complete at that edge, then the sweep SHALL clear it.

Reset
REQ-030 rst_n=0 SHALL immediately, independent of clk, zero all registers, force IDLE, counter=0, busy=0.
REQ-031 Reset asserted mid-sweep SHALL abort the sweep; after release, first edge SHALL be in IDLE.
REQ-032 After reset readData1=readData2=0 for all addresses.

Verification
REQ-033 Write 12 to r1, 15 to r3 (byteEnable all-ones), read r1/r3 -> readData1=12, readData2=15.
REQ-034 r3=0x11223344, write 0xAABBCCDD byteEnable=4'b0101 -> r3=0x11BB33DD; write to r0 -> readData=0.
REQ-035 BYPASS=1, regWrite to r3 value 16 with readRegister1=3 -> readData1=16 same cycle; BYPASS=0 -> old value until edge.
REQ-036 Fill r1..r31 nonzero, pulse clearReq -> busy high 31 cycles, writes during sweep dropped, all registers 0 after busy falls.
REQ-037 Assert rst_n=0 between clock edges mid-sweep -> busy=0 and all reads 0 immediately; after release next write accepted.
REQ-038 clearReq concurrent with write of 7 to r5 -> r5=7 visible next cycle, 0 once sweep passes address 5.

Source files
------------

// File: rtl/register_file_multiport.sv
// Multiport register file: two combinational read ports, one byte-masked write port,
// optional same-cycle write forwarding and a background clear sweep of the whole bank.
module register_file_multiport #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned BYPASS     = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      regWrite,
    input  logic [ADDR_WIDTH-1:0]     writeRegister,
    input  logic [DATA_WIDTH-1:0]     writeData,
    input  logic [DATA_WIDTH/8-1:0]   byteEnable,
    input  logic [ADDR_WIDTH-1:0]     readRegister1,
    input  logic [ADDR_WIDTH-1:0]     readRegister2,
    output logic [DATA_WIDTH-1:0]     readData1,
    output logic [DATA_WIDTH-1:0]     readData2,
    input  logic                      clearReq,
    output logic                      busy
);

    localparam int unsigned DEPTH     = 2 ** ADDR_WIDTH;
    localparam int unsigned BYTES     = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] FIRST_ADDR = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t                  state;
    state_t                  nextState;
    logic [ADDR_WIDTH-1:0]   counter;
    logic [ADDR_WIDTH-1:0]   counterNext;
    logic                    busyNext;
    logic                    clearEn;

    logic [DATA_WIDTH-1:0]   bank [DEPTH];
    logic [DATA_WIDTH-1:0]   mergedWrite;
    logic                    writeAccept;
    logic                    bypass1;
    logic                    bypass2;

    // Clear FSM state, sweep counter and registered busy flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            counter <= '0;
            busy    <= 1'b0;
        end else begin
            state   <= nextState;
            counter <= counterNext;
            busy    <= busyNext;
        end
    end

    // Next state: a sweep runs to the last address and cannot be restarted midway
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (clearReq) nextState = CLEAR;
            CLEAR:   if (counter == LAST_ADDR) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // FSM outputs: counter load/advance, clear strobe, next busy value
    always_comb begin
        clearEn     = 1'b0;
        counterNext = counter;
        busyNext    = (nextState == CLEAR);
        case (state)
            IDLE: begin
                if (clearReq) counterNext = FIRST_ADDR;
            end
            CLEAR: begin
                clearEn     = 1'b1;
                counterNext = counter + ADDR_WIDTH'(1);
            end
            default: begin
                clearEn     = 1'b0;
                counterNext = '0;
            end
        endcase
    end

    assign writeAccept = regWrite && !busy && (writeRegister != '0);

    // Byte-lane merge of incoming data over the current register contents
    always_comb begin
        mergedWrite = bank[writeRegister];
        for (int unsigned b = 0; b < BYTES; b++) begin
            if (byteEnable[b]) mergedWrite[b*8 +: 8] = writeData[b*8 +: 8];
        end
    end

    // Register bank; address 0 is never written and stays zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) bank[i] <= '0;
        end else begin
            if (clearEn) bank[counter] <= '0;
            if (writeAccept) bank[writeRegister] <= mergedWrite;
        end
    end

    assign bypass1 = (BYPASS != 0) && writeAccept && (readRegister1 == writeRegister);
    assign bypass2 = (BYPASS != 0) && writeAccept && (readRegister2 == writeRegister);

    // Combinational read ports with optional forwarding of the accepted write
    always_comb begin
        readData1 = bank[readRegister1];
        if (bypass1) readData1 = mergedWrite;
        if (readRegister1 == '0) readData1 = '0;
    end

    always_comb begin
        readData2 = bank[readRegister2];
        if (bypass2) readData2 = mergedWrite;
        if (readRegister2 == '0) readData2 = '0;
    end

endmodule

// File: tb/tb_register_file_multiport.sv
// Scoreboard bench for register_file_multiport: forwarding and non-forwarding instances
// driven in parallel and checked against an array model of the register bank.
module tb_register_file_multiport;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned DEPTH = 32;
    localparam int unsigned BW    = DW / 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          regWrite;
    logic [AW-1:0] writeRegister;
    logic [DW-1:0] writeData;
    logic [BW-1:0] byteEnable;
    logic [AW-1:0] readRegister1;
    logic [AW-1:0] readRegister2;
    logic          clearReq;
    logic [DW-1:0] rd1A, rd2A, rd1B, rd2B;
    logic          busyA, busyB;

    always #5 clk = ~clk;

    register_file_multiport #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .regWrite(regWrite), .writeRegister(writeRegister),
        .writeData(writeData), .byteEnable(byteEnable), .readRegister1(readRegister1),
        .readRegister2(readRegister2), .readData1(rd1A), .readData2(rd2A),
        .clearReq(clearReq), .busy(busyA)
    );

    register_file_multiport #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYPASS(0)) dutNoBypass (
        .clk(clk), .rst_n(rst_n), .regWrite(regWrite), .writeRegister(writeRegister),
        .writeData(writeData), .byteEnable(byteEnable), .readRegister1(readRegister1),
        .readRegister2(readRegister2), .readData1(rd1B), .readData2(rd2B),
        .clearReq(clearReq), .busy(busyB)
    );

    typedef struct {
        logic [DW-1:0] e1A;
        logic [DW-1:0] e2A;
        logic [DW-1:0] e1B;
        logic [DW-1:0] e2B;
        logic          eBusy;
        int            cyc;
    } exp_t;

    exp_t          sbQ[$];
    int            checks = 0;
    int            fails  = 0;
    int            cycleNo = 0;
    logic [DW-1:0] model [DEPTH];
    int            sweepNext = 0;   // 0 = no sweep, else next address to be zeroed

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] oldV, input logic [DW-1:0] newV,
                                            input logic [BW-1:0] be);
        logic [DW-1:0] r;
        r = oldV;
        for (int b = 0; b < int'(BW); b++) if (be[b]) r[b*8 +: 8] = newV[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [DW-1:0] expRead(input logic [AW-1:0] ra, input bit byp);
        if (ra == '0) return '0;
        if (byp && sweepNext == 0 && regWrite && writeRegister != '0 && ra == writeRegister)
            return merge(model[ra], writeData, byteEnable);
        return model[ra];
    endfunction

    task automatic check(input string name, input int cyc, input logic [DW-1:0] act,
                         input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // One stimulus cycle: drive after the edge, push expectations, advance the model
    task automatic drive(input logic rw, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic [BW-1:0] be, input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                         input logic clr, input logic rst);
        exp_t e;
        @(posedge clk);
        #1;
        cycleNo++;
        regWrite = rw; writeRegister = wa; writeData = wd; byteEnable = be;
        readRegister1 = r1; readRegister2 = r2; clearReq = clr; rst_n = rst;
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;
            sweepNext = 0;
        end
        e.e1A = expRead(r1, 1'b1);
        e.e2A = expRead(r2, 1'b1);
        e.e1B = expRead(r1, 1'b0);
        e.e2B = expRead(r2, 1'b0);
        e.eBusy = (sweepNext != 0);
        e.cyc = cycleNo;
        sbQ.push_back(e);
        if (rst) begin
            if (sweepNext != 0) begin
                model[sweepNext] = '0;
                sweepNext = (sweepNext == int'(DEPTH) - 1) ? 0 : sweepNext + 1;
            end else begin
                if (rw && wa != '0) model[wa] = merge(model[wa], wd, be);
                if (clr) sweepNext = 1;
            end
        end
    endtask

    task automatic idleRead(input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        drive(1'b0, '0, '0, '0, r1, r2, 1'b0, 1'b1);
    endtask

    task automatic randomCycle(input logic clr);
        drive(1'($urandom), AW'($urandom), $urandom, BW'($urandom), AW'($urandom),
              AW'($urandom), clr, 1'b1);
    endtask

    task automatic fillAll();
        for (int a = 1; a < int'(DEPTH); a++)
            drive(1'b1, AW'(a), $urandom | 32'h1, '1, AW'(a), AW'($urandom), 1'b0, 1'b1);
    endtask

    // Monitor: compare both instances against the queued expectation every falling edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbQ.size() > 0) begin
                e = sbQ.pop_front();
                check("busy_bypass",   e.cyc, DW'(busyA), DW'(e.eBusy));
                check("busy_nobypass", e.cyc, DW'(busyB), DW'(e.eBusy));
                check("rd1_bypass",    e.cyc, rd1A, e.e1A);
                check("rd2_bypass",    e.cyc, rd2A, e.e2A);
                check("rd1_nobypass",  e.cyc, rd1B, e.e1B);
                check("rd2_nobypass",  e.cyc, rd2B, e.e2B);
            end
        end
    end

    initial begin
        rst_n = 1'b0; regWrite = 1'b0; writeRegister = '0; writeData = '0; byteEnable = '0;
        readRegister1 = '0; readRegister2 = '0; clearReq = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;

        // Reset and post-reset reads
        repeat (3) drive(1'b0, '0, '0, '0, AW'($urandom), AW'($urandom), 1'b0, 1'b0);
        for (int a = 0; a < int'(DEPTH); a += 4) idleRead(AW'(a), AW'(a + 1));

        // Basic writes and reads
        drive(1'b1, 5'd1, 32'd12, '1, 5'd0, 5'd0, 1'b0, 1'b1);
        drive(1'b1, 5'd3, 32'd15, '1, 5'd1, 5'd0, 1'b0, 1'b1);
        idleRead(5'd1, 5'd3);

        // Byte-lane merge, address 0, empty byte mask
        drive(1'b1, 5'd3, 32'h11223344, '1, 5'd3, 5'd1, 1'b0, 1'b1);
        drive(1'b1, 5'd3, 32'hAABBCCDD, 4'b0101, 5'd3, 5'd3, 1'b0, 1'b1);
        idleRead(5'd3, 5'd3);
        drive(1'b1, 5'd0, 32'hDEADBEEF, '1, 5'd0, 5'd0, 1'b0, 1'b1);
        idleRead(5'd0, 5'd3);
        drive(1'b1, 5'd3, 32'hFFFFFFFF, 4'b0000, 5'd3, 5'd3, 1'b0, 1'b1);

        // Forwarding vs. no forwarding
        drive(1'b1, 5'd3, 32'd16, '1, 5'd3, 5'd1, 1'b0, 1'b1);
        idleRead(5'd3, 5'd3);

        // Randomized traffic with occasional clears
        for (int n = 0; n < 300; n++) randomCycle(1'($urandom_range(0, 39) == 0));
        repeat (35) idleRead(AW'($urandom), AW'($urandom));

        // Full bank clear with writes attempted during the sweep
        fillAll();
        drive(1'b0, '0, '0, '0, 5'd7, 5'd31, 1'b1, 1'b1);
        repeat (31) randomCycle(1'b0);
        for (int a = 0; a < int'(DEPTH); a++) idleRead(AW'(a), AW'(DEPTH - 1 - a));

        // Write coinciding with a clear request
        drive(1'b1, 5'd9, 32'h0000AAAA, '1, 5'd0, 5'd0, 1'b0, 1'b1);
        drive(1'b1, 5'd5, 32'd7, '1, 5'd5, 5'd9, 1'b1, 1'b1);
        repeat (34) idleRead(5'd5, AW'($urandom));

        // Reset in the middle of a sweep
        fillAll();
        drive(1'b0, '0, '0, '0, 5'd20, 5'd30, 1'b1, 1'b1);
        repeat (10) idleRead(AW'($urandom), AW'($urandom));
        repeat (2) drive(1'b0, '0, '0, '0, AW'($urandom), AW'($urandom), 1'b0, 1'b0);
        drive(1'b1, 5'd9, 32'h55, '1, 5'd9, 5'd20, 1'b0, 1'b1);
        idleRead(5'd9, 5'd30);

        // clearReq held high across sweep completion restarts the sweep
        fillAll();
        repeat (70) randomCycle(1'b1);
        repeat (35) idleRead(AW'($urandom), AW'($urandom));

        repeat (3) @(posedge clk);
        if (sbQ.size() != 0) begin
            checks++;
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sbQ.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
